// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer:
// opcodes, function codes, state codes and ALU control values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  function automatic logic funct_legal(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the sequencer's ALUOp plus the R-type Funct field
// onto the 3-bit ALU operation select.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: Moore control per state,
// PC enable from Branch/Zero, memory ready handshake.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state;
  state_t state_next;
  aluop_t alu_op;
  logic   ready;
  logic   illegal;
  logic   ir_write;
  logic   pc_write;
  logic   branch;
  logic   mem_write;
  logic   reg_write;
  logic   take_branch;

  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_comb begin
    state_next = S_FETCH;
    illegal    = 1'b0;
    case (state)
      S_FETCH:  state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_J:           state_next = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal(Funct)) state_next = S_EXEC;
            else illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    IorD      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    reg_write = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = ready;
        pc_write = ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // bne inverts the sense of Zero
  assign take_branch = branch & (Zero ^ (Op == OP_BNE));

  assign IRWrite   = ir_write & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign PCEn      = (pc_write | take_branch) & ~reset;
  assign IllegalOp = illegal;
  assign State     = state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed per-cycle vectors pushed to a scoreboard queue;
// a negedge monitor pops and compares the full control word.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, PCEn;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       IllegalOp;
  logic [3:0] State;

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCEn       (PCEn),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .IllegalOp  (IllegalOp),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMPO = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // word: IorD MemWrite IRWrite PCEn RegDst MemtoReg RegWrite
  //       ALUSrcA ALUSrcB[2] PCSrc[2] ALUControl[3] IllegalOp State[4]
  localparam logic [19:0] IOD    = 20'h80000;
  localparam logic [19:0] MW     = 20'h40000;
  localparam logic [19:0] IRW    = 20'h20000;
  localparam logic [19:0] PCE    = 20'h10000;
  localparam logic [19:0] RDS    = 20'h08000;
  localparam logic [19:0] M2R    = 20'h04000;
  localparam logic [19:0] RW     = 20'h02000;
  localparam logic [19:0] SA     = 20'h01000;
  localparam logic [19:0] SB_4   = 20'h00400;
  localparam logic [19:0] SB_IMM = 20'h00800;
  localparam logic [19:0] SB_SH  = 20'h00C00;
  localparam logic [19:0] PS_OUT = 20'h00100;
  localparam logic [19:0] PS_J   = 20'h00200;
  localparam logic [19:0] AC_AND = 20'h00000;
  localparam logic [19:0] AC_OR  = 20'h00020;
  localparam logic [19:0] AC_ADD = 20'h00040;
  localparam logic [19:0] AC_SUB = 20'h000C0;
  localparam logic [19:0] AC_SLT = 20'h000E0;
  localparam logic [19:0] ILL    = 20'h00010;

  localparam logic [19:0] F1   = IRW | PCE | SB_4 | AC_ADD;
  localparam logic [19:0] F0   = SB_4 | AC_ADD;
  localparam logic [19:0] DEC  = SB_SH | AC_ADD | 20'd1;
  localparam logic [19:0] MA   = SA | SB_IMM | AC_ADD | 20'd2;
  localparam logic [19:0] MR   = IOD | AC_ADD | 20'd3;
  localparam logic [19:0] MWB  = M2R | RW | AC_ADD | 20'd4;
  localparam logic [19:0] MWR  = IOD | MW | AC_ADD | 20'd5;
  localparam logic [19:0] EX   = SA | 20'd6;
  localparam logic [19:0] AWB  = RDS | RW | AC_ADD | 20'd7;
  localparam logic [19:0] BR   = SA | AC_SUB | PS_OUT | 20'd8;
  localparam logic [19:0] AEX  = SA | SB_IMM | AC_ADD | 20'd9;
  localparam logic [19:0] AWBI = RW | AC_ADD | 20'd10;
  localparam logic [19:0] JMP  = PS_J | PCE | AC_ADD | 20'd11;

  typedef struct {
    string       nm;
    logic [19:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [19:0] got;
  assign got = {IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
                IllegalOp, State};

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (got !== e.w) begin
          errors++;
          $display("FAIL %s: got %05h want %05h", e.nm, got, e.w);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic mr, input logic [19:0] w);
    exp_t e;
    Op       = op;
    Funct    = fn;
    Zero     = z;
    MemReady = mr;
    e.nm = nm;
    e.w  = w;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    reset = 1'b1;
    Op = LW; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_hold", LW, 6'd0, 0, 1, F0);
    cyc("rst_hold2", LW, 6'd0, 0, 1, F0);
    reset = 1'b0;

    cyc("lw_f", LW, 6'd0, 0, 1, F1);
    cyc("lw_d", LW, 6'd0, 0, 1, DEC);
    cyc("lw_adr", LW, 6'd0, 0, 1, MA);
    cyc("lw_rd", LW, 6'd0, 0, 1, MR);
    cyc("lw_wb", LW, 6'd0, 0, 1, MWB);

    cyc("f_stall", LW, 6'd0, 0, 0, F0);
    cyc("lw2_f", LW, 6'd0, 0, 1, F1);
    cyc("lw2_d", LW, 6'd0, 0, 1, DEC);
    cyc("lw2_adr", LW, 6'd0, 0, 0, MA);
    cyc("lw2_rd_wait", LW, 6'd0, 0, 0, MR);
    cyc("lw2_rd", LW, 6'd0, 0, 1, MR);
    cyc("lw2_wb", LW, 6'd0, 0, 0, MWB);

    cyc("sw_f", SW, 6'd0, 0, 1, F1);
    cyc("sw_d", SW, 6'd0, 0, 1, DEC);
    cyc("sw_adr", SW, 6'd0, 0, 1, MA);
    for (int i = 0; i < 3; i++)
      cyc("sw_wr_wait", SW, 6'd0, 0, 0, MWR);
    cyc("sw_wr", SW, 6'd0, 0, 1, MWR);

    cyc("beq1_f", BEQ, 6'd0, 1, 1, F1);
    cyc("beq1_d", BEQ, 6'd0, 1, 1, DEC);
    cyc("beq_z1", BEQ, 6'd0, 1, 1, BR | PCE);
    cyc("beq0_f", BEQ, 6'd0, 0, 1, F1);
    cyc("beq0_d", BEQ, 6'd0, 0, 1, DEC);
    cyc("beq_z0", BEQ, 6'd0, 0, 1, BR);
    cyc("bne0_f", BNE, 6'd0, 0, 1, F1);
    cyc("bne0_d", BNE, 6'd0, 0, 1, DEC);
    cyc("bne_z0", BNE, 6'd0, 0, 1, BR | PCE);
    cyc("bne1_f", BNE, 6'd0, 1, 1, F1);
    cyc("bne1_d", BNE, 6'd0, 1, 1, DEC);
    cyc("bne_z1", BNE, 6'd0, 1, 1, BR);

    cyc("slt_f", RT, 6'b101010, 0, 1, F1);
    cyc("slt_d", RT, 6'b101010, 0, 1, DEC);
    cyc("slt_ex", RT, 6'b101010, 0, 1, EX | AC_SLT);
    cyc("slt_wb", RT, 6'b101010, 0, 1, AWB);
    cyc("sub_f", RT, 6'b100010, 0, 1, F1);
    cyc("sub_d", RT, 6'b100010, 0, 1, DEC);
    cyc("sub_ex", RT, 6'b100010, 0, 1, EX | AC_SUB);
    cyc("sub_wb", RT, 6'b100010, 0, 1, AWB);
    cyc("and_f", RT, 6'b100100, 0, 1, F1);
    cyc("and_d", RT, 6'b100100, 0, 1, DEC);
    cyc("and_ex", RT, 6'b100100, 0, 1, EX | AC_AND);
    cyc("and_wb", RT, 6'b100100, 0, 1, AWB);
    cyc("or_f", RT, 6'b100101, 0, 1, F1);
    cyc("or_d", RT, 6'b100101, 0, 1, DEC);
    cyc("or_ex", RT, 6'b100101, 0, 1, EX | AC_OR);
    cyc("or_wb", RT, 6'b100101, 0, 1, AWB);
    cyc("add_f", RT, 6'b100000, 0, 1, F1);
    cyc("add_d", RT, 6'b100000, 0, 1, DEC);
    cyc("add_ex", RT, 6'b100000, 0, 1, EX | AC_ADD);
    cyc("add_wb", RT, 6'b100000, 0, 1, AWB);

    cyc("rbad_f", RT, 6'b000001, 0, 1, F1);
    cyc("rbad_d", RT, 6'b000001, 0, 1, DEC | ILL);

    cyc("addi_f", ADDI, 6'd0, 0, 1, F1);
    cyc("addi_d", ADDI, 6'd0, 0, 1, DEC);
    cyc("addi_ex", ADDI, 6'd0, 0, 1, AEX);
    cyc("addi_wb", ADDI, 6'd0, 0, 1, AWBI);

    cyc("j_f", JMPO, 6'd0, 0, 1, F1);
    cyc("j_d", JMPO, 6'd0, 0, 1, DEC);
    cyc("j_jump", JMPO, 6'd0, 0, 1, JMP);

    cyc("bad_f", BAD, 6'd0, 0, 1, F1);
    cyc("bad_d", BAD, 6'd0, 0, 1, DEC | ILL);
    cyc("bad_next", BAD, 6'd0, 0, 1, F1);

    cyc("swr_d", SW, 6'd0, 0, 1, DEC);
    cyc("swr_adr", SW, 6'd0, 0, 1, MA);
    cyc("swr_wr", SW, 6'd0, 0, 0, MWR);
    reset = 1'b1;
    cyc("swr_rst", SW, 6'd0, 0, 0, F0);
    cyc("swr_rst_mr", SW, 6'd0, 0, 1, F0);
    reset = 1'b0;
    cyc("post_rst_f", LW, 6'd0, 0, 1, F1);
    cyc("post_rst_d", LW, 6'd0, 0, 1, DEC);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle MIPS control sequencer that drives the shared single-ALU, single-memory datapath across Fetch/Decode/Execute/Mem/Writeback cycles. It decodes Op/Funct from the instruction register and issues per-state Moore control signals. It generates the PC enable from Branch/Zero and waits on a memory ready handshake. It replaces the single-cycle control decoder when the datapath is built multicycle.

Parameters:
MEM_HANDSHAKE, 1, 1 = honour MemReady in memory states; 0 = treat MemReady as constant 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
Op  in  6  opcode from instruction register, stable from DECODE until the next FETCH
Funct  in  6  function field from instruction register
Zero  in  1  ALU zero flag
MemReady  in  1  memory access completes this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register load
PCEn  out  1  PC load enable
RegDst  out  1  write register select: 0 = rt, 1 = rd
MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = Data
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
ALUControl  out  3  ALU operation
IllegalOp  out  1  one-cycle pulse for an unsupported instruction
State  out  4  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Reset: State=FETCH asynchronously. While reset=1, IRWrite, PCEn, MemWrite and RegWrite are forced to 0. Every other output takes its FETCH value.
- Outputs are Moore and decoded from State. An output not listed for a state is 0, except ALUSrcB, ALUOp and PCSrc, which are 00.
- FETCH: ALUSrcB=01, IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcB=11 (branch target precompute). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 with a legal Funct -> EXEC
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other Op, or Op=000000 with an unsupported Funct -> FETCH with IllegalOp=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1 every cycle until and including the MemReady=1 cycle. Next state FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- PCEn = PCWrite | (Branch & (Zero ^ (Op==000101))). Combinational.
- ALU decode:
  - ALUOp 00 -> 010 (add); 01 -> 110 (sub).
  - ALUOp 10 by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other Funct -> 010.
- Latency, with MemReady=1: lw 5 cycles; sw and R-type 4; addi 4; beq, bne and j 3.
- Reset asserted mid-instruction: the instruction is abandoned and no write enable pulses. After reset release, execution starts in FETCH.
- MemReady is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.

Decomposition:
- Package mips_ctrl_pkg: opcode constants, Funct constants, state enum (4-bit), ALUOp codes and ALUControl codes.
- Sub-module alu_decoder: combinational ALUOp/Funct -> ALUControl. The FSM instantiates it once.

Test Plan:
- Reset during MEMWR (MemWrite=1) -> MemWrite drops to 0 the same cycle; State=0; IRWrite=0 until reset=0.
- lw (Op=100011), MemReady=1 -> States 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in State 4; total 5 cycles.
- sw with MemReady held 0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then State=0.
- beq, Zero=1 -> PCEn=1 in BRANCH. beq, Zero=0 -> PCEn=0. bne, Zero=0 -> PCEn=1.
- R-type Funct=101010 -> ALUControl=111 in EXEC; RegDst=1 and RegWrite=1 in ALUWB.
- Op=111111 -> IllegalOp=1 for one cycle in DECODE; next State=0; no RegWrite or MemWrite.
